// File: rtl/stream_decipher_rx.sv
// Serial stream decipher receiver: hunts for a 4-bit sync word, then XORs each
// received ciphertext nibble with a 4-bit LFSR keystream seeded from the stored key.
module stream_decipher_rx #(
  parameter logic [3:0] SYNC          = 4'b1011,
  parameter int         FRAME_NIBBLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       key_load,
  input  logic       rx_bit,
  input  logic       rx_valid,
  output logic [3:0] msg,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic       sync_lock,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

  localparam logic [3:0] LAST_NIB = 4'(FRAME_NIBBLES - 1);

  state_t     state_q;
  logic [3:0] key_q;
  logic [3:0] lfsr_q;
  logic [3:0] sr_q;
  logic [1:0] bit_cnt_q;
  logic [3:0] nib_cnt_q;
  logic [3:0] msg_q;
  logic       msg_valid_q;
  logic       sync_lock_q;
  logic       overrun_q;

  logic [3:0] sr_d;
  logic [3:0] lfsr_d;
  logic       consume;

  assign sr_d    = {sr_q[2:0], rx_bit};
  assign lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign consume = msg_valid_q && msg_ready;

  // NOTE: all state below is updated with non-blocking assignments so every
  // read in this block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      key_q       <= 4'b0000;
      lfsr_q      <= 4'b0000;
      sr_q        <= 4'b0000;
      bit_cnt_q   <= 2'd0;
      nib_cnt_q   <= 4'd0;
      msg_q       <= 4'b0000;
      msg_valid_q <= 1'b0;
      sync_lock_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (consume) msg_valid_q <= 1'b0;

      if (key_load) begin
        // An all-zero seed would lock the LFSR at zero forever.
        key_q       <= (key == 4'b0000) ? 4'b0001 : key;
        state_q     <= HUNT;
        sync_lock_q <= 1'b0;
        sr_q        <= 4'b0000;
        bit_cnt_q   <= 2'd0;
        nib_cnt_q   <= 4'd0;
        msg_valid_q <= 1'b0;
      end else if (rx_valid) begin
        case (state_q)
          HUNT: begin
            sr_q <= sr_d;
            if (sr_d == SYNC) begin
              state_q     <= RECV;
              sync_lock_q <= 1'b1;
              bit_cnt_q   <= 2'd0;
              nib_cnt_q   <= 4'd0;
              lfsr_q      <= key_q;
            end
          end
          RECV: begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_q + 2'd1;
            if (bit_cnt_q == 2'd3) begin
              // Keystream advances even for a dropped nibble to stay aligned.
              lfsr_q <= lfsr_d;
              if (msg_valid_q && !msg_ready) begin
                overrun_q <= 1'b1;
              end else begin
                msg_q       <= sr_d ^ lfsr_q;
                msg_valid_q <= 1'b1;
              end
              if (nib_cnt_q == LAST_NIB) begin
                state_q     <= HUNT;
                sync_lock_q <= 1'b0;
                sr_q        <= 4'b0000;
                nib_cnt_q   <= 4'd0;
              end else begin
                nib_cnt_q <= nib_cnt_q + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign msg       = msg_q;
  assign msg_valid = msg_valid_q;
  assign sync_lock = sync_lock_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_stream_decipher_rx.sv
// Bench for stream_decipher_rx: per-cycle vector table plus a plaintext scoreboard
// on the default-frame instance, and a hand sequence on a one-nibble-frame instance.
module tb_stream_decipher_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] a_key, b_key;
  logic       a_key_load, b_key_load;
  logic       a_rx_bit, b_rx_bit;
  logic       a_rx_valid, b_rx_valid;
  logic       a_msg_ready, b_msg_ready;
  logic [3:0] a_msg, b_msg;
  logic       a_msg_valid, b_msg_valid;
  logic       a_sync_lock, b_sync_lock;
  logic       a_overrun, b_overrun;

  stream_decipher_rx dut_a (
    .clk(clk), .reset(reset), .key(a_key), .key_load(a_key_load),
    .rx_bit(a_rx_bit), .rx_valid(a_rx_valid), .msg(a_msg), .msg_valid(a_msg_valid),
    .msg_ready(a_msg_ready), .sync_lock(a_sync_lock), .overrun(a_overrun)
  );

  stream_decipher_rx #(.SYNC(4'b1011), .FRAME_NIBBLES(1)) dut_b (
    .clk(clk), .reset(reset), .key(b_key), .key_load(b_key_load),
    .rx_bit(b_rx_bit), .rx_valid(b_rx_valid), .msg(b_msg), .msg_valid(b_msg_valid),
    .msg_ready(b_msg_ready), .sync_lock(b_sync_lock), .overrun(b_overrun)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic       kl;
    logic [3:0] key;
    logic       rv;
    logic       rb;
    logic       rdy;
    logic [3:0] e_msg;
    logic       e_mv;
    logic       e_lock;
    logic       e_ovr;
    logic       push;
    logic [3:0] pval;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  function automatic void add(input logic kl, input logic [3:0] k, input logic rv,
                              input logic rb, input logic rdy, input logic [3:0] em,
                              input logic emv, input logic elk, input logic eov,
                              input logic push = 1'b0, input logic [3:0] pval = 4'h0);
    vecs.push_back('{kl, k, rv, rb, rdy, em, emv, elk, eov, push, pval});
  endfunction

  // Scoreboard: a handshake is seen at the negedge before the accepting posedge.
  always @(negedge clk) begin
    if (!reset && !a_key_load && a_msg_valid && a_msg_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got %b, expected no delivery", a_msg);
      end else begin
        check("sb_msg", a_msg, exp_q.pop_front());
      end
    end
  end

  task automatic a_step(input logic kl, input logic [3:0] k, input logic rv,
                        input logic rb, input logic rdy);
    a_key_load = kl; a_key = k; a_rx_valid = rv; a_rx_bit = rb; a_msg_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic b_step(input string name, input logic kl, input logic [3:0] k,
                        input logic rv, input logic rb, input logic [3:0] em,
                        input logic emv, input logic elk);
    b_key_load = kl; b_key = k; b_rx_valid = rv; b_rx_bit = rb;
    @(posedge clk);
    #1;
    check({name, "_msg"},  b_msg, em);
    check({name, "_mv"},   b_msg_valid, emv);
    check({name, "_lock"}, b_sync_lock, elk);
  endtask

  initial begin
    logic [7:0] post_rst;

    reset = 1'b1;
    a_key = 4'h0; a_key_load = 1'b0; a_rx_bit = 1'b0; a_rx_valid = 1'b0; a_msg_ready = 1'b0;
    b_key = 4'h0; b_key_load = 1'b0; b_rx_bit = 1'b0; b_rx_valid = 1'b0; b_msg_ready = 1'b1;

    // IDLE ignores bits, even a perfect sync word
    add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0); add(0, 0, 1, 0, 1, 4'h0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0); add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0);
    // key 1001, sync 1011, cipher 0110 -> 1111, then 0011 -> 0000
    add(1, 4'h9, 0, 0, 1, 4'h0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0); add(0, 0, 1, 0, 1, 4'h0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0); add(0, 0, 1, 1, 1, 4'h0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 4'h0, 0, 1, 0); add(0, 0, 1, 1, 1, 4'h0, 0, 1, 0);
    add(0, 0, 1, 1, 1, 4'h0, 0, 1, 0); add(0, 0, 1, 0, 1, 4'hF, 1, 1, 0, 1, 4'hF);
    add(0, 0, 1, 0, 1, 4'hF, 0, 1, 0); add(0, 0, 1, 0, 1, 4'hF, 0, 1, 0);
    add(0, 0, 1, 1, 1, 4'hF, 0, 1, 0); add(0, 0, 1, 1, 1, 4'h0, 1, 1, 0, 1, 4'h0);
    // nibble 3: 1010 ^ 0110 = 1100; nibble 4: 0010 ^ 1101 = 1111, frame ends
    add(0, 0, 1, 1, 1, 4'h0, 0, 1, 0); add(0, 0, 1, 0, 1, 4'h0, 0, 1, 0);
    add(0, 0, 1, 1, 1, 4'h0, 0, 1, 0); add(0, 0, 1, 0, 1, 4'hC, 1, 1, 0, 1, 4'hC);
    add(0, 0, 1, 0, 1, 4'hC, 0, 1, 0); add(0, 0, 1, 0, 1, 4'hC, 0, 1, 0);
    add(0, 0, 1, 1, 1, 4'hC, 0, 1, 0); add(0, 0, 1, 0, 0, 4'hF, 1, 0, 0, 1, 4'hF);
    add(0, 0, 0, 0, 0, 4'hF, 1, 0, 0); add(0, 0, 0, 0, 1, 4'hF, 0, 0, 0);
    // resync with retained key, consumer stalled: A kept, B dropped, C uses lfsr 0110
    add(0, 0, 1, 1, 0, 4'hF, 0, 0, 0); add(0, 0, 1, 0, 0, 4'hF, 0, 0, 0);
    add(0, 0, 1, 1, 0, 4'hF, 0, 0, 0); add(0, 0, 1, 1, 0, 4'hF, 0, 1, 0);
    add(0, 0, 1, 0, 0, 4'hF, 0, 1, 0); add(0, 0, 1, 1, 0, 4'hF, 0, 1, 0);
    add(0, 0, 1, 1, 0, 4'hF, 0, 1, 0); add(0, 0, 1, 0, 0, 4'hF, 1, 1, 0, 1, 4'hF);
    add(0, 0, 1, 1, 0, 4'hF, 1, 1, 0); add(0, 0, 1, 1, 0, 4'hF, 1, 1, 0);
    add(0, 0, 1, 1, 0, 4'hF, 1, 1, 0); add(0, 0, 1, 1, 0, 4'hF, 1, 1, 1);
    add(0, 0, 1, 0, 1, 4'hF, 0, 1, 0); add(0, 0, 1, 1, 1, 4'hF, 0, 1, 0);
    add(0, 0, 1, 0, 1, 4'hF, 0, 1, 0); add(0, 0, 1, 1, 1, 4'h3, 1, 1, 0, 1, 4'h3);
    // nibble 4 completes on the edge that consumes the old one: no overrun
    add(0, 0, 1, 1, 0, 4'h3, 1, 1, 0); add(0, 0, 1, 1, 0, 4'h3, 1, 1, 0);
    add(0, 0, 1, 0, 0, 4'h3, 1, 1, 0); add(0, 0, 1, 1, 1, 4'h0, 1, 0, 0, 1, 4'h0);
    add(0, 0, 0, 0, 1, 4'h0, 0, 0, 0);
    // key 0000 -> 0001; key_load drops the simultaneous bit; rx_valid low is a no-op
    add(1, 4'h0, 1, 1, 1, 4'h0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 4'h0, 0, 0, 0); add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0); add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 4'h0, 0, 0, 0); add(0, 0, 1, 1, 1, 4'h0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 4'h0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 4'h0, 0, 1, 0); add(0, 0, 1, 0, 1, 4'h0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 4'h0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 4'h0, 0, 1, 0); add(0, 0, 1, 0, 0, 4'h1, 1, 1, 0, 1, 4'h1);
    // two bits of the next nibble with msg pending
    add(0, 0, 1, 1, 0, 4'h1, 1, 1, 0); add(0, 0, 1, 1, 0, 4'h1, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_msg",  a_msg, 4'h0);
    check("rst_mv",   a_msg_valid, 1'b0);
    check("rst_lock", a_sync_lock, 1'b0);
    check("rst_ovr",  a_overrun, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].push) exp_q.push_back(vecs[i].pval);
      a_step(vecs[i].kl, vecs[i].key, vecs[i].rv, vecs[i].rb, vecs[i].rdy);
      check($sformatf("vec%0d_msg", i),  a_msg,       vecs[i].e_msg);
      check($sformatf("vec%0d_mv", i),   a_msg_valid, vecs[i].e_mv);
      check($sformatf("vec%0d_lock", i), a_sync_lock, vecs[i].e_lock);
      check($sformatf("vec%0d_ovr", i),  a_overrun,   vecs[i].e_ovr);
    end

    // Mid-frame asynchronous reset: outputs clear without a clock edge
    reset = 1'b1;
    #2;
    check("arst_msg",  a_msg, 4'h0);
    check("arst_mv",   a_msg_valid, 1'b0);
    check("arst_lock", a_sync_lock, 1'b0);
    check("arst_ovr",  a_overrun, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    post_rst = 8'b1011_0110;
    for (int i = 7; i >= 0; i--) begin
      a_step(0, 0, 1, post_rst[i], 1);
      check($sformatf("post_rst%0d_lock", i), a_sync_lock, 1'b0);
      check($sformatf("post_rst%0d_mv", i),   a_msg_valid, 1'b0);
    end
    a_step(1, 4'h9, 0, 0, 1);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) exp_q.push_back(4'hF);
      a_step(0, 0, 1, post_rst[i], 1);
    end
    check("relock_msg",  a_msg, 4'hF);
    check("relock_mv",   a_msg_valid, 1'b1);
    check("relock_lock", a_sync_lock, 1'b1);
    a_step(0, 0, 0, 0, 1);
    check("relock_drain", a_msg_valid, 1'b0);

    // One-nibble frames: sliding sync in noise, return to HUNT with sr cleared
    b_step("b_kl", 1, 4'h5, 0, 0, 4'h0, 0, 0);
    b_step("b_n0", 0, 0, 1, 1, 4'h0, 0, 0);
    b_step("b_n1", 0, 0, 1, 1, 4'h0, 0, 0);
    b_step("b_n2", 0, 0, 1, 1, 4'h0, 0, 0);
    b_step("b_n3", 0, 0, 1, 0, 4'h0, 0, 0);
    b_step("b_n4", 0, 0, 1, 1, 4'h0, 0, 0);
    b_step("b_n5", 0, 0, 1, 1, 4'h0, 0, 1);
    b_step("b_c0", 0, 0, 1, 0, 4'h0, 0, 1);
    b_step("b_c1", 0, 0, 1, 1, 4'h0, 0, 1);
    b_step("b_c2", 0, 0, 1, 1, 4'h0, 0, 1);
    b_step("b_c3", 0, 0, 1, 0, 4'h3, 1, 0);
    check("b_ovr", b_overrun, 1'b0);
    b_step("b_idle", 0, 0, 0, 0, 4'h3, 0, 0);
    b_step("b_s0", 0, 0, 1, 1, 4'h3, 0, 0);
    b_step("b_s1", 0, 0, 1, 1, 4'h3, 0, 0);
    b_step("b_s2", 0, 0, 1, 0, 4'h3, 0, 0);
    b_step("b_s3", 0, 0, 1, 1, 4'h3, 0, 0);
    b_step("b_s4", 0, 0, 1, 1, 4'h3, 0, 1);
    b_step("b_d0", 0, 0, 1, 0, 4'h3, 0, 1);
    b_step("b_d1", 0, 0, 1, 1, 4'h3, 0, 1);
    b_step("b_d2", 0, 0, 1, 1, 4'h3, 0, 1);
    b_step("b_d3", 0, 0, 1, 0, 4'h3, 1, 0);

    check("sb_drained", 4'(exp_q.size()), 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_decipher_rx.md
STREAM_DECIPHER_RX -- requirements
Module: stream_decipher_rx

Interface
REQ-001 SHALL have parameter SYNC, default 4'b1011: frame sync word, MSB received first.
REQ-002 SHALL have parameter FRAME_NIBBLES, default 4: ciphertext nibbles per frame, range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port key, input, 4 bits: keystream seed, sampled when key_load is high.
REQ-006 SHALL have port key_load, input, 1 bit: load key and restart sync hunt.
REQ-007 SHALL have port rx_bit, input, 1 bit: serial ciphertext/sync bit.
REQ-008 SHALL have port rx_valid, input, 1 bit: rx_bit is accepted on each clk edge where rx_valid is high.
REQ-009 SHALL have port msg, output, 4 bits: deciphered nibble.
REQ-010 SHALL have port msg_valid, output, 1 bit: msg holds an undelivered nibble.
REQ-011 SHALL have port msg_ready, input, 1 bit: the consumer accepts msg when msg_valid and msg_ready are both high on an edge.
REQ-012 SHALL have port sync_lock, output, 1 bit: high while in RECV.
REQ-013 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed nibble is dropped.

Function
REQ-014 SHALL implement states IDLE, HUNT and RECV.
REQ-015 In IDLE, accepted bits SHALL be ignored; key_load SHALL go to HUNT.
REQ-016 key_load in any state SHALL store key and go to HUNT.
REQ-017 key_load SHALL clear the shift register, the bit counter, the nibble counter and msg_valid.
REQ-018 A stored key of 4'b0000 SHALL be replaced by 4'b0001.
REQ-019 key_load SHALL win over a simultaneous rx_valid; that bit is dropped.
REQ-020 Each accepted bit SHALL shift in MSB-first: sr <= {sr[2:0], rx_bit}.
REQ-021 In HUNT, when the updated sr equals SYNC, the block SHALL enter RECV on that edge.
REQ-022 On RECV entry, the block SHALL clear the bit and nibble counters and load the LFSR with the stored key.
REQ-023 In HUNT, sync matching SHALL slide bit by bit; no alignment is required.
REQ-024 In RECV, every 4th accepted bit SHALL complete a nibble c = {sr[2:0], rx_bit}.
REQ-025 For each completed nibble, plaintext SHALL be c XOR lfsr.
REQ-026 For each completed nibble, the LFSR SHALL step once: lfsr <= {lfsr[2:0], lfsr[3]^lfsr[2]}.
REQ-027 The LFSR SHALL step once per completed nibble even when that nibble is dropped.
REQ-028 Latency: msg and msg_valid SHALL update on the same edge that accepts the 4th bit.
REQ-029 Output buffer: single entry; msg SHALL stay stable while msg_valid is high.
REQ-030 If a nibble completes while msg_valid is high and msg_ready is low, the new nibble SHALL be dropped, the old one kept, and overrun pulsed.
REQ-031 If a nibble completes on the same edge msg_ready accepts the old one, the new nibble SHALL load without overrun.
REQ-032 Consumption without a new nibble SHALL clear msg_valid.
REQ-033 After FRAME_NIBBLES nibbles have completed, the block SHALL return to HUNT with sr cleared.
REQ-034 After FRAME_NIBBLES nibbles, the stored key SHALL be retained; the next frame restarts the keystream from the key.
REQ-035 A pending msg_valid SHALL survive the RECV->HUNT transition.
REQ-036 Edges with rx_valid low SHALL change no counters and no shift state.

Reset
REQ-037 Reset SHALL take effect asynchronously and force state IDLE.
REQ-038 Reset SHALL clear the key, LFSR, sr and counters to 0.
REQ-039 Reset SHALL drive msg=4'b0000, msg_valid=0, sync_lock=0 and overrun=0.
REQ-040 Reset asserted mid-frame SHALL abort the frame, discarding partial bits and any pending msg.
REQ-041 After reset release, the block SHALL stay in IDLE until key_load.

Verification
REQ-042 Scenario: key=4'b1001 load; bits 1011 then 0110, msg_ready=1 -> sync_lock rises after the 4th sync bit; msg=4'b1111 with msg_valid one cycle wide.
REQ-043 Scenario: continue with cipher 0011 -> msg=4'b0000 (LFSR 4'b1001->4'b0011).
REQ-044 Scenario: msg_ready=0, two nibbles completed -> first nibble held, overrun pulses once; the third nibble still deciphers with the correct LFSR step.
REQ-045 Scenario: key=4'b0000, sync, cipher 0000 -> msg=4'b0001.
REQ-046 Scenario: sync noise 1110110 then 11, FRAME_NIBBLES=1 -> lock only at the first true 1011 match; one nibble later the block returns to HUNT with sync_lock=0.
REQ-047 Scenario: reset asserted after 2 bits of a nibble with msg_valid=1 -> all outputs 0 immediately; rx bits are ignored until key_load.
